id_ex_pipeline_reg: RTL and testbench



---
 rtl/id_ex_pipeline_reg.sv | 90 +++++++++
 tb/tb_id_ex_pipeline_reg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg.sv
// Decode-to-execute pipeline register for the 5-stage RV32I core.
// Captures the decode control word and operands; supports stall (hold) and flush (bubble).
module id_ex_pipeline_reg #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned ALU_CTRL_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      StallE,
  input  logic                      FlushE,
  input  logic                      ValidD,
  input  logic [1:0]                ResultSrcD,
  input  logic                      MemWriteD,
  input  logic                      MemReadD,
  input  logic [ALU_CTRL_WIDTH-1:0] ALUControlD,
  input  logic                      ALUSrcD,
  input  logic                      RegWriteD,
  input  logic                      JumpD,
  input  logic                      BranchD,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [DATA_WIDTH-1:0]     PCPlus4D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  output logic                      ValidE,
  output logic [1:0]                ResultSrcE,
  output logic                      MemWriteE,
  output logic                      MemReadE,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControlE,
  output logic                      ALUSrcE,
  output logic                      RegWriteE,
  output logic                      JumpE,
  output logic                      BranchE,
  output logic [DATA_WIDTH-1:0]     RD1E,
  output logic [DATA_WIDTH-1:0]     RD2E,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [DATA_WIDTH-1:0]     PCPlus4E,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE
);

  // Reset and flush both produce an all-zero bubble; flush outranks stall.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      ValidE      <= 1'b0;
      ResultSrcE  <= '0;
      MemWriteE   <= 1'b0;
      MemReadE    <= 1'b0;
      ALUControlE <= '0;
      ALUSrcE     <= 1'b0;
      RegWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
    end else if (!StallE) begin
      ValidE      <= ValidD;
      ResultSrcE  <= ResultSrcD;
      ALUControlE <= ALUControlD;
      ALUSrcE     <= ALUSrcD;
      // An invalid decode slot must never commit, whatever control_unit decoded.
      MemWriteE   <= MemWriteD & ValidD;
      MemReadE    <= MemReadD  & ValidD;
      RegWriteE   <= RegWriteD & ValidD;
      JumpE       <= JumpD     & ValidD;
      BranchE     <= BranchD   & ValidD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      ImmExtE     <= ImmExtD;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Table-driven bench for id_ex_pipeline_reg: reset, load, stall, flush, invalid slot,
// plus hand-written sequences for long stalls and the absence of combinational paths.
module tb_id_ex_pipeline_reg;

  typedef struct packed {
    logic [1:0]  rsrc;
    logic        mw;
    logic        mr;
    logic [3:0]  alu;
    logic        asrc;
    logic        rw;
    logic        jmp;
    logic        br;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        v;
  } word_t;

  typedef struct {
    logic  rst;
    logic  flush;
    logic  stall;
    word_t d;
    word_t exp;
  } vec_t;

  localparam word_t ZERO = '0;
  localparam word_t GARB = '{rsrc:2'b11, mw:1'b1, mr:1'b1, alu:4'hF, asrc:1'b1, rw:1'b1, jmp:1'b1, br:1'b1,
    rd1:32'hDEADBEEF, rd2:32'hCAFEF00D, imm:32'hFFFFFFFF, pc:32'h12345678, pc4:32'h1234567C,
    rs1:5'd31, rs2:5'd30, rd:5'd29, v:1'b1};
  localparam word_t ADD  = '{rsrc:2'b00, mw:1'b0, mr:1'b0, alu:4'b0000, asrc:1'b0, rw:1'b1, jmp:1'b0, br:1'b0,
    rd1:32'd5, rd2:32'd7, imm:32'd0, pc:32'h100, pc4:32'h104, rs1:5'd1, rs2:5'd2, rd:5'd3, v:1'b1};
  localparam word_t LW   = '{rsrc:2'b01, mw:1'b0, mr:1'b1, alu:4'b0000, asrc:1'b1, rw:1'b1, jmp:1'b0, br:1'b0,
    rd1:32'h1000, rd2:32'd0, imm:32'd8, pc:32'h104, pc4:32'h108, rs1:5'd1, rs2:5'd0, rd:5'd4, v:1'b1};
  localparam word_t SW   = '{rsrc:2'b00, mw:1'b1, mr:1'b0, alu:4'b0000, asrc:1'b1, rw:1'b0, jmp:1'b0, br:1'b0,
    rd1:32'h1000, rd2:32'h55, imm:32'd12, pc:32'h108, pc4:32'h10C, rs1:5'd1, rs2:5'd5, rd:5'd0, v:1'b1};
  localparam word_t BEQ  = '{rsrc:2'b00, mw:1'b0, mr:1'b0, alu:4'b0001, asrc:1'b0, rw:1'b0, jmp:1'b0, br:1'b1,
    rd1:32'd9, rd2:32'd9, imm:32'd16, pc:32'h10C, pc4:32'h110, rs1:5'd1, rs2:5'd2, rd:5'd0, v:1'b1};
  localparam word_t JAL  = '{rsrc:2'b10, mw:1'b0, mr:1'b0, alu:4'b0000, asrc:1'b0, rw:1'b1, jmp:1'b1, br:1'b0,
    rd1:32'd0, rd2:32'd0, imm:32'h20, pc:32'h110, pc4:32'h114, rs1:5'd0, rs2:5'd0, rd:5'd1, v:1'b1};
  localparam word_t INV  = '{rsrc:2'b01, mw:1'b1, mr:1'b1, alu:4'b0010, asrc:1'b1, rw:1'b1, jmp:1'b1, br:1'b1,
    rd1:32'h1234, rd2:32'h5678, imm:32'd3, pc:32'h200, pc4:32'h204, rs1:5'd6, rs2:5'd7, rd:5'd8, v:1'b0};
  localparam word_t INVE = '{rsrc:2'b01, mw:1'b0, mr:1'b0, alu:4'b0010, asrc:1'b1, rw:1'b0, jmp:1'b0, br:1'b0,
    rd1:32'h1234, rd2:32'h5678, imm:32'd3, pc:32'h200, pc4:32'h204, rs1:5'd6, rs2:5'd7, rd:5'd8, v:1'b0};

  logic clk = 1'b0;
  logic rst, StallE, FlushE;
  word_t d, q;

  logic ValidD, MemWriteD, MemReadD, ALUSrcD, RegWriteD, JumpD, BranchD;
  logic [1:0] ResultSrcD;
  logic [3:0] ALUControlD;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic ValidE, MemWriteE, MemReadE, ALUSrcE, RegWriteE, JumpE, BranchE;
  logic [1:0] ResultSrcE;
  logic [3:0] ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;

  assign {ResultSrcD, MemWriteD, MemReadD, ALUControlD, ALUSrcD, RegWriteD, JumpD, BranchD,
          RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, ValidD} = d;
  assign q = {ResultSrcE, MemWriteE, MemReadE, ALUControlE, ALUSrcE, RegWriteE, JumpE, BranchE,
              RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE};

  always #5 clk = ~clk;

  id_ex_pipeline_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ALU_CTRL_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .MemReadD(MemReadD), .ALUControlD(ALUControlD),
    .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(ValidE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .MemReadE(MemReadE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input word_t got, input word_t exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  task automatic drive(input logic r, input logic f, input logic s, input word_t w);
    rst = r; FlushE = f; StallE = s; d = w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[17];

  initial begin
    vt[0]  = '{1'b1, 1'b0, 1'b0, GARB, ZERO};
    vt[1]  = '{1'b1, 1'b0, 1'b0, GARB, ZERO};
    vt[2]  = '{1'b0, 1'b0, 1'b0, ADD,  ADD};
    vt[3]  = '{1'b0, 1'b0, 1'b0, LW,   LW};
    vt[4]  = '{1'b0, 1'b0, 1'b1, SW,   LW};
    vt[5]  = '{1'b0, 1'b0, 1'b1, SW,   LW};
    vt[6]  = '{1'b0, 1'b0, 1'b1, SW,   LW};
    vt[7]  = '{1'b0, 1'b0, 1'b0, SW,   SW};
    vt[8]  = '{1'b0, 1'b1, 1'b0, BEQ,  ZERO};
    vt[9]  = '{1'b0, 1'b0, 1'b0, BEQ,  BEQ};
    vt[10] = '{1'b0, 1'b0, 1'b0, JAL,  JAL};
    vt[11] = '{1'b0, 1'b1, 1'b1, ADD,  ZERO};
    vt[12] = '{1'b0, 1'b0, 1'b0, INV,  INVE};
    vt[13] = '{1'b0, 1'b0, 1'b0, ADD,  ADD};
    vt[14] = '{1'b1, 1'b0, 1'b1, GARB, ZERO};
    vt[15] = '{1'b1, 1'b1, 1'b0, GARB, ZERO};
    vt[16] = '{1'b0, 1'b0, 1'b0, ADD,  ADD};

    drive(1'b1, 1'b0, 1'b0, GARB);
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].rst, vt[i].flush, vt[i].stall, vt[i].d);
      step();
      chk($sformatf("vec%0d", i), q, vt[i].exp);
    end

    // Inputs changing mid-cycle must not reach the outputs before an edge.
    d = GARB; rst = 1'b0; FlushE = 1'b1; StallE = 1'b0;
    #2;
    chk("no_comb_path", q, ADD);

    // Long stall: contents frozen while decode values churn.
    drive(1'b0, 1'b0, 1'b0, LW);
    step();
    chk("long_stall_load", q, LW);
    StallE = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d = word_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      step();
      chk($sformatf("long_stall%0d", i), q, LW);
    end
    drive(1'b0, 1'b0, 1'b0, JAL);
    step();
    chk("after_long_stall", q, JAL);

    // Stall holding a bubble keeps the bubble.
    drive(1'b0, 1'b1, 1'b0, BEQ);
    step();
    chk("flush_pulse", q, ZERO);
    drive(1'b0, 1'b0, 1'b1, BEQ);
    step();
    chk("stall_bubble", q, ZERO);
    drive(1'b0, 1'b0, 1'b0, BEQ);
    step();
    chk("load_after_bubble", q, BEQ);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
